demux16_frame_writer: RTL and testbench
=======================================

// Module: demux16_frame_writer
// PURPOSE
//   Receive-side counterpart of the 16:1 strobed selector. Routes a single data bit,
//   tagged with a 4-bit lane select, into a registered 16-lane bank. Unwritten lanes
//   idle high, matching the selector's strobe-inactive output. Once every lane has
//   been written, the bank is presented as one frame through a valid/ready handshake.
//   Sits between a serial bit source and a consumer of parallel 16-bit words.
// PARAMETERS
//   LANES     16  number of output lanes; fixed at 16, parameter used for widths only
//   SEL_W     4   lane select width, log2(LANES)
//   AUTO_INC  0   1 = ignore in_sel and write lanes 0..15 in order from an internal pointer
// PORTS
//   clock         in   1      single clock, rising edge
//   reset         in   1      synchronous, active-high
//   clear         in   1      synchronous frame abort
//   in_valid      in   1      input beat valid
//   in_ready      out  1      input beat accepted when in_valid & in_ready
//   in_sel        in   SEL_W  target lane (ignored when AUTO_INC=1)
//   in_bit        in   1      data bit for the lane
//   in_strobe_n   in   1      active-low strobe; 1 = beat consumed, no lane written
//   frame_valid   out  1      full frame available on frame_data
//   frame_ready   in   1      consumer takes frame when frame_valid & frame_ready
//   frame_data    out  LANES  lane bank; bit i = lane i
//   lane_mask     out  LANES  bit i set = lane i written in current frame
//   overwrite_err out  1      one-cycle pulse: a lane was written twice in one frame
// BEHAVIOUR
//   - State machine with two states: FILL and HOLD. Reset state is FILL.
//   - Reset values: frame_data = all ones, lane_mask = 0, frame_valid = 0,
//     overwrite_err = 0, pointer = 0. in_ready = 0 while reset is high.
//   - in_ready = (state == FILL) & ~clear & ~reset. This is combinational, with no
//     dependency on in_valid.
//   - FILL, accepted beat with in_strobe_n = 0:
//     - lane L = in_sel, or the pointer when AUTO_INC = 1.
//     - frame_data[L] <= in_bit and lane_mask[L] <= 1.
//     - Both are visible on the next cycle (1-cycle latency).
//   - FILL, accepted beat with in_strobe_n = 1: beat is consumed. No change to data,
//     mask or pointer.
//   - Rewrite of a lane already set in lane_mask: data is overwritten, the mask is
//     unchanged, and overwrite_err = 1 on the next cycle only.
//   - AUTO_INC pointer:
//     - increments on each strobed write and wraps 15 -> 0;
//     - returns to 0 on frame completion and on clear;
//     - overwrite_err can therefore only assert after a clear-free wrap, which cannot
//       happen because HOLD is entered first.
//   - Transition to HOLD: the cycle after the write that makes lane_mask all ones.
//     From then on, frame_valid = 1 and in_ready = 0.
//   - HOLD:
//     - frame_data and lane_mask are held stable and frame_valid stays 1 until
//       frame_ready.
//     - On frame_valid & frame_ready, the next cycle is FILL with frame_data = all
//       ones, lane_mask = 0 and frame_valid = 0.
//     - A new beat can be accepted in that next cycle, so frames can run back to back.
//   - clear: in either state, the next cycle is FILL with data all ones, mask 0,
//     pointer 0 and frame_valid 0. An in-flight frame is discarded with no handshake.
//   - Priority: reset > clear > frame handshake > input beat.
//   - A reset or clear in the middle of a frame loses that partial frame. No error
//     is flagged.
//   - frame_data is driven from registers only, with no combinational path from the
//     inputs.
// TESTING
//   - Reset: hold reset for 2 cycles.
//     -> frame_data = 16'hFFFF, lane_mask = 0, in_ready = 0 during reset and 1 in the
//        first cycle after.
//   - Fill out of order, AUTO_INC = 0: write sel 15..0 with bit = sel[0], strobe_n = 0.
//     -> The cycle after the 16th beat: frame_valid = 1, frame_data = 16'hAAAA,
//        in_ready = 0.
//   - Back-pressure, then handshake: keep frame_ready = 0 for 5 cycles.
//     -> Data is stable and in_valid is ignored.
//     -> Then frame_ready = 1 for 1 cycle; the next cycle is FILL with data 16'hFFFF
//        and mask 0.
//   - Strobe and overwrite: a beat with sel = 3, strobe_n = 1 leaves the mask
//     unchanged. Then sel = 3 with bit 0, then sel = 3 with bit 1.
//     -> One overwrite_err pulse, frame_data[3] = 1, lane_mask = 16'h0008.
//   - AUTO_INC = 1: 16 strobed beats with in_sel randomised and bits 0,1,1,0 repeated.
//     -> frame_data = 16'h6666 and the pointer returns to 0.
//   - clear: assert clear after 9 writes.
//     -> in_ready = 0 in that cycle; the next cycle has mask 0 and data 16'hFFFF.
//     -> The following 16 writes complete a frame normally.

Source files
------------

// File: rtl/demux16_frame_writer.sv
// Strobed 16-lane receive bank: single-bit beats fill lanes, and the full bank
// is handed to the consumer as one frame through a valid/ready handshake.
module demux16_frame_writer #(
   parameter int unsigned LANES    = 16,
   parameter int unsigned SEL_W    = 4,
   parameter int unsigned AUTO_INC = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_bit,
   input  logic             in_strobe_n,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [LANES-1:0] frame_data,
   output logic [LANES-1:0] lane_mask,
   output logic             overwrite_err
);

   typedef enum logic {StFill, StHold} state_e;

   state_e             state_q, state_d;
   logic [LANES-1:0]   data_q, data_d;
   logic [LANES-1:0]   mask_q, mask_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic               err_q, err_d;
   logic [SEL_W-1:0]   lane;

   assign in_ready = (state_q == StFill) & ~clear & ~reset;
   assign lane     = (AUTO_INC != 0) ? ptr_q : in_sel;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mask_d  = mask_q;
      ptr_d   = ptr_q;
      err_d   = 1'b0;
      if (clear) begin
         state_d = StFill;
         data_d  = '1;
         mask_d  = '0;
         ptr_d   = '0;
      end else if (state_q == StHold) begin
         if (frame_ready) begin
            state_d = StFill;
            data_d  = '1;
            mask_d  = '0;
            ptr_d   = '0;
         end
      end else if (in_valid && !in_strobe_n) begin
         // in_ready is implied here: FILL, no clear, and reset wins in the register
         data_d[lane] = in_bit;
         mask_d[lane] = 1'b1;
         err_d        = mask_q[lane];
         ptr_d        = ptr_q + SEL_W'(1);
         if (&mask_d) begin
            state_d = StHold;
            ptr_d   = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StFill;
         data_q  <= '1;
         mask_q  <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   assign frame_valid   = (state_q == StHold);
   assign frame_data    = data_q;
   assign lane_mask     = mask_q;
   assign overwrite_err = err_q;

endmodule

// File: tb/tb_demux16_frame_writer.sv
// Directed bench for demux16_frame_writer: one instance with explicit lane
// select and one with the internal auto-increment pointer.
module tb_demux16_frame_writer;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear, in_valid, in_bit, in_strobe_n, frame_ready;
   logic [3:0]  in_sel;
   logic        in_ready, frame_valid, overwrite_err;
   logic [15:0] frame_data, lane_mask;

   logic        a_clear, a_in_valid, a_in_bit, a_in_strobe_n, a_frame_ready;
   logic [3:0]  a_in_sel;
   logic        a_in_ready, a_frame_valid, a_overwrite_err;
   logic [15:0] a_frame_data, a_lane_mask;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   demux16_frame_writer #(.LANES(16), .SEL_W(4), .AUTO_INC(0)) dut (
      .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready), .in_sel(in_sel), .in_bit(in_bit), .in_strobe_n(in_strobe_n),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
      .lane_mask(lane_mask), .overwrite_err(overwrite_err)
   );

   demux16_frame_writer #(.LANES(16), .SEL_W(4), .AUTO_INC(1)) dut_auto (
      .clock(clock), .reset(reset), .clear(a_clear), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .in_sel(a_in_sel), .in_bit(a_in_bit),
      .in_strobe_n(a_in_strobe_n), .frame_valid(a_frame_valid),
      .frame_ready(a_frame_ready), .frame_data(a_frame_data),
      .lane_mask(a_lane_mask), .overwrite_err(a_overwrite_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [3:0] pat;
      pat = 4'b0110;
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_strobe_n = 1'b1;
      frame_ready = 1'b0; in_sel = 4'd0;
      a_clear = 1'b0; a_in_valid = 1'b0; a_in_bit = 1'b0; a_in_strobe_n = 1'b1;
      a_frame_ready = 1'b0; a_in_sel = 4'd0;

      // Reset held for two cycles
      step();
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_data", {16'd0, frame_data}, 32'h0000FFFF);
      chk("rst_mask", {16'd0, lane_mask}, 32'd0);
      step();
      chk("rst_valid", {31'd0, frame_valid}, 32'd0);
      chk("rst_err", {31'd0, overwrite_err}, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

      // Out-of-order fill, lane 15 first
      for (int s = 15; s >= 0; s--) begin
         in_valid = 1'b1; in_sel = 4'(s); in_bit = s[0]; in_strobe_n = 1'b0;
         step();
      end
      chk("fill_valid", {31'd0, frame_valid}, 32'd1);
      chk("fill_data", {16'd0, frame_data}, 32'h0000AAAA);
      chk("fill_ready", {31'd0, in_ready}, 32'd0);
      chk("fill_err", {31'd0, overwrite_err}, 32'd0);

      // Back-pressure with beats offered that must be ignored
      in_sel = 4'd1; in_bit = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("bp_data", {16'd0, frame_data}, 32'h0000AAAA);
      chk("bp_mask", {16'd0, lane_mask}, 32'h0000FFFF);
      chk("bp_valid", {31'd0, frame_valid}, 32'd1);
      in_valid = 1'b0; frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      chk("hs_valid", {31'd0, frame_valid}, 32'd0);
      chk("hs_data", {16'd0, frame_data}, 32'h0000FFFF);
      chk("hs_mask", {16'd0, lane_mask}, 32'd0);
      chk("hs_ready", {31'd0, in_ready}, 32'd1);

      // Strobe-inactive beat, then write lane 3 twice
      in_valid = 1'b1; in_sel = 4'd3; in_bit = 1'b0; in_strobe_n = 1'b1;
      step();
      chk("nostb_mask", {16'd0, lane_mask}, 32'd0);
      chk("nostb_data", {16'd0, frame_data}, 32'h0000FFFF);
      in_strobe_n = 1'b0;
      step();
      chk("w3_mask", {16'd0, lane_mask}, 32'h00000008);
      chk("w3_data", {16'd0, frame_data}, 32'h0000FFF7);
      chk("w3_err", {31'd0, overwrite_err}, 32'd0);
      in_bit = 1'b1;
      step();
      in_valid = 1'b0;
      chk("ow_err", {31'd0, overwrite_err}, 32'd1);
      chk("ow_data", {16'd0, frame_data}, 32'h0000FFFF);
      chk("ow_mask", {16'd0, lane_mask}, 32'h00000008);
      step();
      chk("ow_err_pulse", {31'd0, overwrite_err}, 32'd0);

      // Clear the partial frame, write 9 lanes, then clear mid-frame
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr0_mask", {16'd0, lane_mask}, 32'd0);
      for (int s = 0; s < 9; s++) begin
         in_valid = 1'b1; in_sel = 4'(s); in_bit = 1'b0; in_strobe_n = 1'b0;
         step();
      end
      chk("nine_mask", {16'd0, lane_mask}, 32'h000001FF);
      chk("nine_data", {16'd0, frame_data}, 32'h0000FE00);
      clear = 1'b1;
      #1;
      chk("clr_ready", {31'd0, in_ready}, 32'd0);
      step();
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_mask", {16'd0, lane_mask}, 32'd0);
      chk("clr_data", {16'd0, frame_data}, 32'h0000FFFF);
      chk("clr_valid", {31'd0, frame_valid}, 32'd0);
      for (int s = 0; s < 16; s++) begin
         in_valid = 1'b1; in_sel = 4'(s); in_bit = ~s[0]; in_strobe_n = 1'b0;
         step();
      end
      in_valid = 1'b0;
      chk("refill_valid", {31'd0, frame_valid}, 32'd1);
      chk("refill_data", {16'd0, frame_data}, 32'h00005555);

      // Auto-increment instance: in_sel is noise
      for (int i = 0; i < 16; i++) begin
         a_in_valid = 1'b1; a_in_sel = 4'($urandom_range(0, 15));
         a_in_bit = pat[i % 4]; a_in_strobe_n = 1'b0;
         step();
         if (i == 0) chk("auto_first_mask", {16'd0, a_lane_mask}, 32'h00000001);
      end
      a_in_valid = 1'b0;
      chk("auto_valid", {31'd0, a_frame_valid}, 32'd1);
      chk("auto_data", {16'd0, a_frame_data}, 32'h00006666);
      chk("auto_mask", {16'd0, a_lane_mask}, 32'h0000FFFF);
      a_frame_ready = 1'b1;
      step();
      a_frame_ready = 1'b0;
      chk("auto_hs_valid", {31'd0, a_frame_valid}, 32'd0);
      a_in_valid = 1'b1; a_in_sel = 4'd9; a_in_bit = 1'b0;
      step();
      a_in_valid = 1'b0;
      chk("auto_ptr0_mask", {16'd0, a_lane_mask}, 32'h00000001);
      chk("auto_ptr0_data", {16'd0, a_frame_data}, 32'h0000FFFE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
